// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line counters plus registered
// sync, blanking, display-enable and line/frame start strobes.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 1024,
    parameter int   H_FP     = 24,
    parameter int   H_SYNC   = 136,
    parameter int   H_BP     = 160,
    parameter int   V_ACTIVE = 768,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 29,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   CNT_W    = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    input  logic             resync,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hblnk,
    output logic             vblnk,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_BLK      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_BLK      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    if ((H_TOTAL - 1) >= (2 ** CNT_W) || (V_TOTAL - 1) >= (2 ** CNT_W)) begin : g_cnt_w_err
        $fatal(1, "vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0)
    begin : g_zero_err
        $fatal(1, "vga_timing_gen: porch and sync parameters must be non-zero");
    end

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             active_q, active_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             pend_q, pend_d;

    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        pend_d        = pend_q;

        if (pix_en) begin
            pend_d = 1'b0;
            // A resync landing on the natural wrap collapses into the same (0,0) load.
            if (resync || pend_q) begin
                hcount_d      = '0;
                vcount_d      = '0;
                line_start_d  = 1'b1;
                frame_start_d = 1'b1;
            end else if (hcount_q == H_LAST) begin
                hcount_d     = '0;
                line_start_d = 1'b1;
                if (vcount_q == V_LAST) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 1'b1;
                end
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end else begin
            pend_d = pend_q | resync;
        end

        // Decoded from next-state counters so the registered flags line up with the counts.
        hblnk_d  = (hcount_d >= H_BLK);
        vblnk_d  = (vcount_d >= V_BLK);
        hsync_d  = (hcount_d >= HS_START && hcount_d < HS_END) ? HS_POL : ~HS_POL;
        vsync_d  = (vcount_d >= VS_START && vcount_d < VS_END) ? VS_POL : ~VS_POL;
        active_d = ~hblnk_d & ~vblnk_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            active_q      <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            pend_q        <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            pend_q        <= pend_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets driven in lockstep and compared
// against a raster-position reference model, plus directed vectors and sequences.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_en = 1'b0;
    logic resync = 1'b0;

    always #5 clk = ~clk;

    logic [10:0] hc0, vc0, hc1, vc1;
    logic [4:0]  hc2, vc2;
    logic [2:0]  hb, vb, hs, vs, ac, ls, fs;

    vga_timing_gen dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .resync(resync),
        .hcount(hc0), .vcount(vc0), .hblnk(hb[0]), .vblnk(vb[0]), .hsync(hs[0]),
        .vsync(vs[0]), .active(ac[0]), .line_start(ls[0]), .frame_start(fs[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(11)
    ) dut_vga (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .resync(resync),
        .hcount(hc1), .vcount(vc1), .hblnk(hb[1]), .vblnk(vb[1]), .hsync(hs[1]),
        .vsync(vs[1]), .active(ac[1]), .line_start(ls[1]), .frame_start(fs[1])
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .CNT_W(5)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .resync(resync),
        .hcount(hc2), .vcount(vc2), .hblnk(hb[2]), .vblnk(vb[2]), .hsync(hs[2]),
        .vsync(vs[2]), .active(ac[2]), .line_start(ls[2]), .frame_start(fs[2])
    );

    // Per-instance timing parameters, mirrored from the instantiations above.
    int ha[3]  = '{1024, 640, 8};
    int hfp[3] = '{24, 16, 2};
    int hsw[3] = '{136, 96, 3};
    int hbp[3] = '{160, 48, 2};
    int va[3]  = '{768, 480, 5};
    int vfp[3] = '{3, 10, 1};
    int vsw[3] = '{6, 2, 2};
    int vbp[3] = '{29, 33, 1};
    bit hpol[3] = '{1'b1, 1'b0, 1'b0};
    bit vpol[3] = '{1'b1, 1'b0, 1'b1};

    // Model state: linear raster position within the frame plus pending resync.
    int mp[3];
    bit mpend[3], mls[3], mfs[3];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int htot(int i);
        return ha[i] + hfp[i] + hsw[i] + hbp[i];
    endfunction

    function automatic int vtot(int i);
        return va[i] + vfp[i] + vsw[i] + vbp[i];
    endfunction

    function automatic logic [28:0] model_out(int i);
        int h, v;
        bit hbl, vbl, hsy, vsy;
        h   = mp[i] % htot(i);
        v   = mp[i] / htot(i);
        hbl = (h >= ha[i]);
        vbl = (v >= va[i]);
        hsy = (h >= ha[i] + hfp[i] && h < ha[i] + hfp[i] + hsw[i]) ? hpol[i] : !hpol[i];
        vsy = (v >= va[i] + vfp[i] && v < va[i] + vfp[i] + vsw[i]) ? vpol[i] : !vpol[i];
        return {11'(h), 11'(v), hbl, vbl, hsy, vsy, !hbl && !vbl, mls[i], mfs[i]};
    endfunction

    function automatic logic [28:0] dut_out(int i);
        logic [10:0] h, v;
        case (i)
            0:       begin h = hc0;        v = vc0;        end
            1:       begin h = hc1;        v = vc1;        end
            default: begin h = {6'd0, hc2}; v = {6'd0, vc2}; end
        endcase
        return {h, v, hb[i], vb[i], hs[i], vs[i], ac[i], ls[i], fs[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mp[i] = 0; mpend[i] = 1'b0; mls[i] = 1'b0; mfs[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit pe, input bit rs);
        for (int i = 0; i < 3; i++) begin
            if (pe) begin
                if (rs || mpend[i]) begin
                    mp[i] = 0; mls[i] = 1'b1; mfs[i] = 1'b1;
                end else begin
                    mp[i]  = (mp[i] + 1) % (htot(i) * vtot(i));
                    mls[i] = (mp[i] % htot(i)) == 0;
                    mfs[i] = (mp[i] == 0);
                end
                mpend[i] = 1'b0;
            end else begin
                mpend[i] = mpend[i] | rs;
                mls[i] = 1'b0; mfs[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [28:0] got, exp;
        for (int i = 0; i < 3; i++) begin
            got = dut_out(i);
            exp = model_out(i);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s inst%0d at %0t: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
                         tag, i, $time, got[28:18], got[17:7], got[6:0],
                         exp[28:18], exp[17:7], exp[6:0]);
            end
        end
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit pe, input bit rs);
        @(negedge clk);
        pix_en = pe;
        resync = rs;
        @(posedge clk);
        model_edge(pe, rs);
        #1;
        check_all("step");
    endtask

    // Async reset between edges: outputs must return without a clock.
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n  = 1'b1;
        pix_en = 1'b0;
        resync = 1'b0;
    endtask

    typedef struct {
        bit pe;
        bit rs;
        int h;
        int v;
        bit ls;
        bit fs;
    } vec_t;

    vec_t vecs[$];
    int   cnt0, cnt1, nfs, first_fs, second_fs;

    initial begin
        model_reset();
        #12;
        check_all("power_on_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors for the 15x9 instance, starting from reset.
        vecs.push_back('{1'b1, 1'b0, 1, 0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1, 0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1, 0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1, 0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 0, 0, 1'b1, 1'b1});
        for (int k = 1; k <= 14; k++) vecs.push_back('{1'b1, 1'b0, k, 0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 0, 1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1, 1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 0, 0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1, 0, 1'b0, 1'b0});
        foreach (vecs[k]) begin
            step(vecs[k].pe, vecs[k].rs);
            check($sformatf("vec%0d", k), {hc2, vc2, ls[2], fs[2]},
                  {5'(vecs[k].h), 5'(vecs[k].v), vecs[k].ls, vecs[k].fs});
        end

        // Mid-line reset on the default instance.
        repeat (700) step(1'b1, 1'b0);
        async_reset();

        // Six full default lines: line wrap 5->6 and horizontal sync widths.
        cnt0 = 0; cnt1 = 0;
        for (int k = 0; k < 1344 * 6 + 10; k++) begin
            step(1'b1, 1'b0);
            if (k < 1344) cnt0 += int'(hs[0]);
            if (k < 800)  cnt1 += int'(!hs[1]);
        end
        check("hsync_width_1024", cnt0, 136);
        check("hsync_width_640_low", cnt1, 96);

        // Resync mid-line on a running raster.
        step(1'b1, 1'b1);
        check("resync_mid_line", {hc0, vc0, fs[0], ls[0]}, {22'd0, 2'b11});

        // Frame period of the small instance, continuous and alternating pix_en.
        for (int mode = 0; mode < 2; mode++) begin
            async_reset();
            first_fs = -1; second_fs = -1;
            for (int k = 0; k < 700 && second_fs < 0; k++) begin
                step(mode == 0 || k % 2 == 0, 1'b0);
                if (fs[2]) begin
                    if (first_fs < 0) first_fs = k; else second_fs = k;
                end
            end
            check($sformatf("frame_period_mode%0d", mode), second_fs - first_fs,
                  (mode == 0) ? 135 : 270);
        end

        // Resync coinciding with the natural frame wrap yields one frame_start.
        async_reset();
        nfs = 0;
        for (int k = 0; k < 145; k++) begin
            step(1'b1, k == 134);
            nfs += int'(fs[2]);
        end
        check("resync_at_wrap_single_fs", nfs, 1);

        // Randomised phase against the reference model.
        async_reset();
        for (int k = 0; k < 20000; k++) begin
            if ($urandom_range(0, 4999) == 0) async_reset();
            step($urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
